// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM controller port between the ioctl loader
// (byte writes packed into 16-bit words) and the video line fetcher (word
// reads). Video has priority, bounded by a streak limit while writes wait.
module sdram_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int VID_STREAK_MAX = 4
) (
    input  logic              clk_ram,
    input  logic              reset,
    input  logic              ld_download,
    input  logic              ld_wr,
    input  logic [ADDR_W:0]   ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_wait,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [15:0]       vid_data,
    output logic              vid_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_be,
    input  logic              mem_ready,
    input  logic [15:0]       mem_dout,
    input  logic              mem_dout_valid
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic [1:0]        be;
    } wr_entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

    localparam int STREAK_W = $clog2(VID_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(VID_STREAK_MAX);

    // Write queue (2 entries) and the pending even-byte partial word
    wr_entry_t         q_mem [2];
    logic              q_wr_ptr;
    logic              q_rd_ptr;
    logic [1:0]        q_count;
    logic              part_valid;
    logic [ADDR_W-1:0] part_addr;
    logic [7:0]        part_data;

    state_t            state;
    logic [STREAK_W-1:0] streak;

    logic [ADDR_W-1:0] byte_word;
    logic              byte_odd;
    logic              same_word;
    logic              flush_pending;
    logic              accept;
    logic              pop;
    logic              push0;
    logic              push1;
    logic              part_set;
    logic              part_clr;
    wr_entry_t         part_entry;
    wr_entry_t         odd_entry;
    wr_entry_t         push0_entry;
    wr_entry_t         push1_entry;

    assign byte_word     = ld_addr[ADDR_W:1];
    assign byte_odd      = ld_addr[0];
    assign same_word     = part_valid && (part_addr == byte_word);
    assign flush_pending = !ld_download && part_valid;
    assign ld_wait       = (q_count != 2'd0) || flush_pending;

    assign part_entry = '{addr: part_addr, data: {8'h00, part_data}, be: 2'b01};
    assign odd_entry  = '{addr: byte_word, data: {ld_data, 8'h00}, be: 2'b10};

    // The controller takes the request on mem_req & mem_ready; a read is
    // acknowledged to video on that very cycle, a write retires its entry.
    assign accept  = (state == ISSUE) && mem_req && mem_ready;
    assign pop     = accept && mem_we;
    assign vid_ack = accept && !mem_we;

    // Byte packing: decide which words enter the queue this cycle (partial first)
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        push0       = 1'b0;
        push1       = 1'b0;
        push0_entry = part_entry;
        push1_entry = odd_entry;
        part_set    = 1'b0;
        part_clr    = 1'b0;
        if (ld_wr) begin
            if (!byte_odd) begin
                // An unrelated partial is retired before the new byte replaces it.
                push0    = part_valid && !same_word;
                part_set = 1'b1;
            end else if (same_word) begin
                push0       = 1'b1;
                push0_entry = '{addr: byte_word, data: {ld_data, part_data}, be: 2'b11};
                part_clr    = 1'b1;
            end else if (part_valid) begin
                push0    = 1'b1;
                push1    = 1'b1;
                part_clr = 1'b1;
            end else begin
                push0       = 1'b1;
                push0_entry = odd_entry;
            end
        end else if (flush_pending && (q_count != 2'd2)) begin
            push0    = 1'b1;
            part_clr = 1'b1;
        end
    end

    // Queue storage: written on push, never cleared
    always_ff @(posedge clk_ram) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values. The storage array has no reset: the
        // pointers and count define which entries are live, so clearing those
        // empties the queue.
        if (push0) q_mem[q_wr_ptr]  <= push0_entry;
        if (push1) q_mem[~q_wr_ptr] <= push1_entry;
    end

    // Queue pointers, occupancy and the partial word
    always_ff @(posedge clk_ram) begin
        if (reset) begin
            q_wr_ptr   <= 1'b0;
            q_rd_ptr   <= 1'b0;
            q_count    <= 2'd0;
            part_valid <= 1'b0;
            part_addr  <= '0;
            part_data  <= 8'h00;
        end else begin
            q_wr_ptr <= q_wr_ptr ^ push0 ^ push1;
            if (pop) q_rd_ptr <= ~q_rd_ptr;
            q_count  <= q_count + {1'b0, push0} + {1'b0, push1} - {1'b0, pop};
            if (part_set) begin
                part_valid <= 1'b1;
                part_addr  <= byte_word;
                part_data  <= ld_data;
            end else if (part_clr) begin
                part_valid <= 1'b0;
            end
        end
    end

    // Arbitration FSM: one transaction at a time, all memory-side outputs registered
    always_ff @(posedge clk_ram) begin
        if (reset) begin
            state     <= IDLE;
            streak    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= 16'h0000;
            mem_be    <= 2'b00;
            vid_data  <= 16'h0000;
            vid_valid <= 1'b0;
        end else begin
            vid_valid <= 1'b0;
            // The starvation guard only matters while a write is waiting.
            if (q_count == 2'd0) streak <= '0;
            case (state)
                IDLE: begin
                    if (vid_req && ((q_count == 2'd0) || (streak < STREAK_LIMIT))) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= vid_addr;
                        mem_din  <= 16'h0000;
                        mem_be   <= 2'b11;
                        state    <= ISSUE;
                        if (q_count != 2'd0) streak <= streak + STREAK_W'(1);
                    end else if (q_count != 2'd0) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= q_mem[q_rd_ptr].addr;
                        mem_din  <= q_mem[q_rd_ptr].data;
                        mem_be   <= q_mem[q_rd_ptr].be;
                        streak   <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= mem_we ? IDLE : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_dout_valid) begin
                        vid_data  <= mem_dout;
                        vid_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
